// File: rtl/ultra_pkg.sv
// Shared widths, command opcodes, entry layout and serialiser state for the ultra result FIFO.
package ultra_pkg;

    localparam int unsigned DATA_W  = 20;
    localparam int unsigned META_W  = 16;
    localparam int unsigned ENTRY_W = 36;
    localparam int unsigned CHUNK_W = 9;
    localparam int unsigned CHUNKS  = 4;
    localparam int unsigned CIDX_W  = $clog2(CHUNKS);
    localparam int unsigned BCNT_W  = $clog2(CHUNK_W);

    localparam logic [2:0] OP_READ      = 3'd5;
    localparam logic [2:0] OP_CLR_OFLOW = 3'd6;
    localparam logic [2:0] OP_FLUSH     = 3'd7;

    typedef enum logic [0:0] {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_e;

    typedef struct packed {
        logic [META_W-1:0] meta;
        logic [DATA_W-1:0] data;
    } entry_t;

    // Wire order is LSB first: chunk 0 carries entry bits [8:0].
    function automatic logic [CHUNK_W-1:0] chunk_of(input entry_t e, input logic [CIDX_W-1:0] idx);
        logic [ENTRY_W-1:0] flat;
        flat = e;
        case (idx)
            2'd0:    chunk_of = flat[8:0];
            2'd1:    chunk_of = flat[17:9];
            2'd2:    chunk_of = flat[26:18];
            default: chunk_of = flat[35:27];
        endcase
    endfunction

endpackage

// File: rtl/ultra_chunk_serializer.sv
// Nine-bit load/shift serialiser: emits one chunk LSB first and flags its final bit cycle on done_c_o.
module ultra_chunk_serializer
    import ultra_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               abort_i,
    input  logic               load_i,
    input  logic [CHUNK_W-1:0] chunk_i,
    output logic               bits_o,
    output logic               busy_o,
    output logic               done_c_o
);

    ser_state_e          state_q, state_d;
    logic [CHUNK_W-1:0]  sr_q, sr_d;
    logic [BCNT_W-1:0]   cnt_q, cnt_d;
    logic                bits_q, bits_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SER_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            bits_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
        end
    end

    // Bit 0 goes out on the load edge so bit k appears k+1 cycles after the request.
    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        bits_d   = 1'b0;
        done_c_o = 1'b0;
        case (state_q)
            SER_IDLE: begin
                if (load_i) begin
                    state_d = SER_SHIFT;
                    bits_d  = chunk_i[0];
                    sr_d    = chunk_i >> 1;
                    cnt_d   = '0;
                end
            end
            SER_SHIFT: begin
                if (cnt_q == BCNT_W'(CHUNK_W - 1)) begin
                    state_d  = SER_IDLE;
                    done_c_o = 1'b1;
                end else begin
                    bits_d = sr_q[0];
                    sr_d   = sr_q >> 1;
                    cnt_d  = cnt_q + BCNT_W'(1);
                end
            end
            default: state_d = SER_IDLE;
        endcase
        if (abort_i) begin
            state_d  = SER_IDLE;
            bits_d   = 1'b0;
            done_c_o = 1'b0;
        end
    end

    assign bits_o = bits_q;
    assign busy_o = (state_q == SER_SHIFT);

endmodule

// File: rtl/ultra_result_fifo.sv
// Per-block result FIFO with chunked serial readout and broadcast command decode.
// ULTRA_RESULT_FIFO_META_EN: store the 16-bit meta field; otherwise meta is dropped and reads back as zero.
module ultra_result_fifo
    import ultra_pkg::*;
#(
    parameter int unsigned UNIT  = 0,
    parameter int unsigned DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic [META_W-1:0] in_meta,
    input  logic              in_valid,
    input  logic              fifo_req,
    output logic              fifo_bits,
    output logic              fifo_empty,
    output logic              fifo_oflow,
    input  logic              strobe,
    input  logic [2:0]        opcode,
    input  logic [19:0]       command
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_addr_c;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CIDX_W-1:0]  cidx_q, cidx_d;
    logic               empty_q, empty_d;
    logic               oflow_q, oflow_d;
    logic               nonempty_q, nonempty_d;
    logic               strobe_q;
    logic               cmd_vld_q;
    logic [2:0]         cmd_op_q;
    logic               flush_c, clr_c, load_c, pop_c, wr_c, drop_c, busy_c, done_c;
    logic [CHUNK_W-1:0] load_chunk_c;
    entry_t             head_c;
    logic               unused_cmd;

    assign unused_cmd = ^command[19:8];

`ifdef ULTRA_RESULT_FIFO_META_EN
    entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_c) mem_q[wr_addr_c] <= {in_meta, in_data};
    end

    assign head_c = mem_q[rd_ptr_q];
`else
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              unused_meta;

    always_ff @(posedge clk) begin
        if (wr_c) mem_q[wr_addr_c] <= in_data;
    end

    assign head_c      = {META_W'(0), mem_q[rd_ptr_q]};
    assign unused_meta = ^in_meta;
`endif

    // Command decode runs one cycle behind the strobe toggle; opcode 5 belongs to the controller.
    always_comb begin
        flush_c = 1'b0;
        clr_c   = 1'b0;
        if (cmd_vld_q) begin
            case (cmd_op_q)
                OP_CLR_OFLOW: clr_c   = 1'b1;
                OP_FLUSH:     flush_c = 1'b1;
                OP_READ:      ;
                default:      ;
            endcase
        end
    end

    assign load_c       = fifo_req && !busy_c && !flush_c;
    assign load_chunk_c = (count_q != '0) ? chunk_of(head_c, cidx_q) : '0;
    assign pop_c        = done_c && (cidx_q == CIDX_W'(CHUNKS - 1)) && nonempty_q;
    assign wr_c         = in_valid && (flush_c || (count_q != CNT_W'(DEPTH)) || pop_c);
    assign drop_c       = in_valid && !wr_c;

    always_comb begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(wr_c);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop_c);
        count_d    = count_q + CNT_W'(wr_c) - CNT_W'(pop_c);
        cidx_d     = cidx_q + CIDX_W'(done_c);
        wr_addr_c  = wr_ptr_q;
        nonempty_d = nonempty_q;
        oflow_d    = oflow_q;
        if (load_c) nonempty_d = (count_q != '0);
        // A write in the flush cycle lands in slot 0 of the emptied FIFO.
        if (flush_c) begin
            wr_addr_c = '0;
            wr_ptr_d  = PTR_W'(wr_c);
            rd_ptr_d  = '0;
            count_d   = CNT_W'(wr_c);
            cidx_d    = '0;
        end
        if (clr_c)  oflow_d = 1'b0;
        if (drop_c) oflow_d = 1'b1;
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            cidx_q     <= '0;
            empty_q    <= 1'b1;
            oflow_q    <= 1'b0;
            nonempty_q <= 1'b0;
            strobe_q   <= strobe;
            cmd_vld_q  <= 1'b0;
            cmd_op_q   <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            cidx_q     <= cidx_d;
            empty_q    <= empty_d;
            oflow_q    <= oflow_d;
            nonempty_q <= nonempty_d;
            strobe_q   <= strobe;
            cmd_vld_q  <= (strobe != strobe_q) && (command[7:0] == 8'(UNIT));
            cmd_op_q   <= opcode;
        end
    end

    ultra_chunk_serializer u_ser (
        .clk      (clk),
        .reset    (reset),
        .abort_i  (flush_c),
        .load_i   (load_c),
        .chunk_i  (load_chunk_c),
        .bits_o   (fifo_bits),
        .busy_o   (busy_c),
        .done_c_o (done_c)
    );

    assign fifo_empty = empty_q;
    assign fifo_oflow = oflow_q;

endmodule

// File: tb/tb_ultra_result_fifo.sv
// Directed bench for ultra_result_fifo: serial readout, overflow, empty reads, full write+pop, flush, meta gating.
`timescale 1ns/1ps
module tb_ultra_result_fifo;

    localparam int unsigned UNIT  = 3;
    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] in_data;
    logic [15:0] in_meta;
    logic        in_valid;
    logic        fifo_req;
    logic        fifo_bits;
    logic        fifo_empty;
    logic        fifo_oflow;
    logic        strobe;
    logic [2:0]  opcode;
    logic [19:0] command;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ultra_result_fifo #(.UNIT(UNIT), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_meta    (in_meta),
        .in_valid   (in_valid),
        .fifo_req   (fifo_req),
        .fifo_bits  (fifo_bits),
        .fifo_empty (fifo_empty),
        .fifo_oflow (fifo_oflow),
        .strobe     (strobe),
        .opcode     (opcode),
        .command    (command)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [35:0] exp_entry(input logic [15:0] m, input logic [19:0] d);
`ifdef ULTRA_RESULT_FIFO_META_EN
        return {m, d};
`else
        return {m & 16'h0000, d};
`endif
    endfunction

    task automatic write_entry(input logic [15:0] m, input logic [19:0] d);
        in_meta  = m;
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // One 16-cycle request slot; optionally writes during the last bit cycle (the pop edge).
    task automatic read_chunk(output logic [8:0] c, output logic emp10,
                              input bit wr_at_pop, input logic [15:0] m, input logic [19:0] d);
        c = '0;
        fifo_req = 1'b1;
        tick();
        fifo_req = 1'b0;
        for (int k = 0; k < 9; k++) begin
            c[k] = fifo_bits;
            if (wr_at_pop && k == 8) begin
                in_meta  = m;
                in_data  = d;
                in_valid = 1'b1;
            end
            tick();
            in_valid = 1'b0;
        end
        check("idle_bits", 64'(fifo_bits), 64'd0);
        emp10 = fifo_empty;
        repeat (6) tick();
    endtask

    task automatic read_entry(output logic [35:0] e);
        logic [8:0] c;
        logic       emp;
        e = '0;
        for (int i = 0; i < 4; i++) begin
            read_chunk(c, emp, 1'b0, 16'h0, 20'h0);
            e[i*9 +: 9] = c;
        end
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [7:0] unit);
        opcode  = op;
        command = {12'h000, unit};
        strobe  = ~strobe;
        tick();
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [35:0] e;
        logic [8:0]  c;
        logic        emp;
        logic [8:0]  acc;

        reset    = 1'b1;
        in_data  = '0;
        in_meta  = '0;
        in_valid = 1'b0;
        fifo_req = 1'b0;
        strobe   = 1'b0;
        opcode   = '0;
        command  = '0;
        repeat (3) tick();
        check("rst_bits",  64'(fifo_bits),  64'd0);
        check("rst_empty", 64'(fifo_empty), 64'd1);
        check("rst_oflow", 64'(fifo_oflow), 64'd0);
        reset = 1'b0;
        tick();

        // Single entry, four chunks, pop on the fourth.
        write_entry(16'hA5C3, 20'h12345);
        check("t1_empty_after_wr", 64'(fifo_empty), 64'd0);
        e = '0;
        for (int i = 0; i < 3; i++) begin
            read_chunk(c, emp, 1'b0, 16'h0, 20'h0);
            e[i*9 +: 9] = c;
        end
        check("t1_empty_before_last", 64'(fifo_empty), 64'd0);
        read_chunk(c, emp, 1'b0, 16'h0, 20'h0);
        e[35:27] = c;
        check("t1_empty_after_pop", 64'(emp), 64'd1);
        check("t1_entry", 64'(e), 64'(exp_entry(16'hA5C3, 20'h12345)));

        // Overflow: 17 writes into 16 slots.
        for (int i = 0; i < 16; i++) write_entry(16'(16'hB000 + i), 20'(20'h10000 + i));
        check("t2_oflow_at_full", 64'(fifo_oflow), 64'd0);
        write_entry(16'hDEAD, 20'hDEAD0);
        check("t2_oflow_set", 64'(fifo_oflow), 64'd1);
        for (int i = 0; i < 16; i++) begin
            read_entry(e);
            check($sformatf("t2_order_%0d", i), 64'(e),
                  64'(exp_entry(16'(16'hB000 + i), 20'(20'h10000 + i))));
        end
        check("t2_empty", 64'(fifo_empty), 64'd1);
        send_cmd(3'd6, 8'(UNIT + 1));
        check("t2_clr_other_unit", 64'(fifo_oflow), 64'd1);
        send_cmd(3'd5, 8'(UNIT));
        check("t2_op_read_ignored", 64'(fifo_oflow), 64'd1);
        send_cmd(3'd6, 8'(UNIT));
        check("t2_clr_own_unit", 64'(fifo_oflow), 64'd0);

        // Twenty requests on an empty FIFO, then two entries must come back aligned.
        for (int g = 0; g < 5; g++) begin
            acc = '0;
            for (int i = 0; i < 4; i++) begin
                read_chunk(c, emp, 1'b0, 16'h0, 20'h0);
                acc = acc | c;
            end
            check($sformatf("t3_empty_bits_%0d", g), 64'(acc), 64'd0);
        end
        write_entry(16'h1234, 20'hFEDCB);
        write_entry(16'h8001, 20'h80001);
        read_entry(e);
        check("t3_entry0", 64'(e), 64'(exp_entry(16'h1234, 20'hFEDCB)));
        read_entry(e);
        check("t3_entry1", 64'(e), 64'(exp_entry(16'h8001, 20'h80001)));

        // Full FIFO: write lands on the same edge as the pop.
        for (int i = 0; i < 16; i++) write_entry(16'(16'hC000 + i), 20'(20'h20000 + i));
        e = '0;
        for (int i = 0; i < 4; i++) begin
            read_chunk(c, emp, (i == 3), 16'hC0FF, 20'h2FFFF);
            e[i*9 +: 9] = c;
        end
        check("t4_head", 64'(e), 64'(exp_entry(16'hC000, 20'h20000)));
        check("t4_oflow_clear", 64'(fifo_oflow), 64'd0);
        write_entry(16'hDEAD, 20'hBEEF0);
        check("t4_still_full", 64'(fifo_oflow), 64'd1);
        for (int i = 1; i < 16; i++) begin
            read_entry(e);
            check($sformatf("t4_order_%0d", i), 64'(e),
                  64'(exp_entry(16'(16'hC000 + i), 20'(20'h20000 + i))));
        end
        read_entry(e);
        check("t4_pop_write", 64'(e), 64'(exp_entry(16'hC0FF, 20'h2FFFF)));
        check("t4_empty", 64'(fifo_empty), 64'd1);
        send_cmd(3'd6, 8'(UNIT));
        check("t4_clr", 64'(fifo_oflow), 64'd0);

        // FLUSH lands while chunk bit 4 is on the wire.
        write_entry(16'h0001, 20'h00010);
        write_entry(16'h0002, 20'h00020);
        fifo_req = 1'b1;
        tick();
        fifo_req = 1'b0;
        repeat (3) tick();
        opcode  = 3'd7;
        command = {12'h000, 8'(UNIT)};
        strobe  = ~strobe;
        tick();
        check("t5_bit4", 64'(fifo_bits), 64'd1);
        tick();
        check("t5_bits_flushed", 64'(fifo_bits), 64'd0);
        check("t5_empty", 64'(fifo_empty), 64'd1);
        repeat (12) tick();
        check("t5_bits_quiet", 64'(fifo_bits), 64'd0);
        write_entry(16'h0003, 20'h00333);
        read_entry(e);
        check("t5_realigned", 64'(e), 64'(exp_entry(16'h0003, 20'h00333)));
        check("t5_empty_end", 64'(fifo_empty), 64'd1);

        // FLUSH coinciding with a write keeps just that write.
        write_entry(16'h0004, 20'h00444);
        write_entry(16'h0005, 20'h00555);
        opcode  = 3'd7;
        command = {12'h000, 8'(UNIT)};
        strobe  = ~strobe;
        tick();
        in_meta  = 16'h0006;
        in_data  = 20'h00666;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t6_one_entry", 64'(fifo_empty), 64'd0);
        read_entry(e);
        check("t6_entry", 64'(e), 64'(exp_entry(16'h0006, 20'h00666)));
        check("t6_empty", 64'(fifo_empty), 64'd1);

        // Meta storage depends on the build option.
        write_entry(16'hFFFF, 20'h0ABCD);
        read_entry(e);
        check("t7_meta", 64'(e), 64'(exp_entry(16'hFFFF, 20'h0ABCD)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
